// File: rtl/wb_regmux.sv
// -----------------------------------------------------------------------------
// wb_regmux
//
// Registered Wishbone slave decoder. Splits the user-area address space into
// four regions, selected by wbs_adr_i[31:30]:
//   00  program memory   (write-only, read returns 0)
//   01  pad config       (write-only, read returns 0)
//   10  debug registers  (read with DEBUG_LATENCY wait cycles, write pulse)
//   11  entropy pool     (byte-masked XOR-accumulate on write, readable)
//
// Every access acknowledges from a register. Non-debug accesses ack one cycle
// after the strobe is sampled. Debug reads ack DEBUG_LATENCY+1 cycles after
// the strobe. All write pulses (prog_we, pads_we, debug_we) and the ack last
// exactly one cycle. A master dropping wbs_cyc_i during a debug wait aborts
// the read without an ack.
//
// Optional build macro: WB_REGMUX_ADDR_CHECK_EN
//   When defined, any nonzero address bit between the region field and the
//   decoded index raises a one-cycle wbs_err_o instead of an ack, with no
//   side effects and wbs_dat_o cleared. When undefined those bits alias and
//   wbs_err_o stays 0.
//
// Ports:
//   wb_clk_i, wb_rst_i           clock, synchronous active-high reset
//   wbs_stb_i/cyc_i/we_i/sel_i   Wishbone request controls
//   wbs_adr_i, wbs_dat_i         request address and write data
//   wbs_ack_o, wbs_err_o         registered ack / error
//   wbs_dat_o                    registered read data
//   prog_*                       program memory write port (one-cycle we)
//   pads_*                       pad config write port (one-cycle we)
//   debug_*                      debug register file port (one-cycle we)
//   entropy_word                 current entropy pool value
// -----------------------------------------------------------------------------
module wb_regmux #(
  parameter int LOG_CORES     = 3,
  parameter int PC_WIDTH      = 8,
  parameter int INSTR_WIDTH   = 32,
  parameter int DATA_WIDTH    = 16,
  parameter int IO_PINS       = 16,
  parameter int LOG_PADS      = 1,
  parameter int DEBUG_LATENCY = 1,
  parameter int WB_WIDTH      = 32,
  parameter logic [WB_WIDTH-1:0] ENTROPY_SEED = 'h1
) (
  input  logic                   wb_clk_i,
  input  logic                   wb_rst_i,
  input  logic                   wbs_stb_i,
  input  logic                   wbs_cyc_i,
  input  logic                   wbs_we_i,
  input  logic [WB_WIDTH/8-1:0]  wbs_sel_i,
  input  logic [WB_WIDTH-1:0]    wbs_adr_i,
  input  logic [WB_WIDTH-1:0]    wbs_dat_i,
  output logic                   wbs_ack_o,
  output logic                   wbs_err_o,
  output logic [WB_WIDTH-1:0]    wbs_dat_o,
  output logic                   prog_we,
  output logic [LOG_CORES-1:0]   prog_sel,
  output logic [PC_WIDTH-1:0]    prog_waddr,
  output logic [INSTR_WIDTH-1:0] prog_wdata,
  output logic                   pads_we,
  output logic [LOG_PADS-1:0]    pads_waddr,
  output logic [IO_PINS-1:0]     pads_wdata,
  output logic [LOG_CORES-1:0]   debug_sel,
  output logic [4:0]             debug_addr,
  output logic                   debug_we,
  output logic [DATA_WIDTH-1:0]  debug_wdata,
  input  logic [DATA_WIDTH-1:0]  debug_rdata,
  output logic [WB_WIDTH-1:0]    entropy_word
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DWAIT = 2'd1,
    ACK   = 2'd2
  } state_t;

  localparam logic [1:0] REG_PROG    = 2'b00;
  localparam logic [1:0] REG_PADS    = 2'b01;
  localparam logic [1:0] REG_DEBUG   = 2'b10;
  localparam logic [1:0] REG_ENTROPY = 2'b11;

  state_t     state;
  logic [3:0] wait_cnt;
  logic       err_q;
  logic       req;
  logic [1:0] region;
  logic       addr_err;

  assign req    = wbs_stb_i & wbs_cyc_i;
  assign region = wbs_adr_i[31:30];

  // Address bits outside the decoded fields are only inspected by the
  // optional address check; this keeps the rest of the bus visibly consumed.
  logic unused_adr;
  assign unused_adr = ^wbs_adr_i;

`ifdef WB_REGMUX_ADDR_CHECK_EN
  // Masks cover the bits between the region field and each region's index.
  localparam logic [29:0] PROG_MASK  = ~((30'd1 << (PC_WIDTH + LOG_CORES)) - 30'd1);
  localparam logic [29:0] PADS_MASK  = ~((30'd1 << LOG_PADS) - 30'd1);
  localparam logic [29:0] DEBUG_MASK = ~((30'd1 << (LOG_CORES + 5)) - 30'd1);

  // Flag a request whose unused address bits are not all zero.
  always_comb begin
    addr_err = 1'b0;
    case (region)
      REG_PROG:  addr_err = |(wbs_adr_i[29:0] & PROG_MASK);
      REG_PADS:  addr_err = |(wbs_adr_i[29:0] & PADS_MASK);
      REG_DEBUG: addr_err = |(wbs_adr_i[29:0] & DEBUG_MASK);
      default:   addr_err = |wbs_adr_i[29:0];
    endcase
  end
`else
  // Without the check, stray address bits simply alias; no error path exists.
  assign addr_err = 1'b0;
`endif

  assign wbs_err_o = err_q;

  // Single sequential process: request decode, debug wait counter, register
  // side effects and the one-cycle ack/err/write pulses. The pulse outputs
  // default low every cycle, so they can only ever be high for one cycle.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state        <= IDLE;
      wait_cnt     <= 4'd0;
      wbs_ack_o    <= 1'b0;
      err_q        <= 1'b0;
      wbs_dat_o    <= '0;
      prog_we      <= 1'b0;
      prog_sel     <= '0;
      prog_waddr   <= '0;
      prog_wdata   <= '0;
      pads_we      <= 1'b0;
      pads_waddr   <= '0;
      pads_wdata   <= '0;
      debug_sel    <= '0;
      debug_addr   <= '0;
      debug_we     <= 1'b0;
      debug_wdata  <= '0;
      entropy_word <= ENTROPY_SEED;
    end else begin
      wbs_ack_o <= 1'b0;
      err_q     <= 1'b0;
      prog_we   <= 1'b0;
      pads_we   <= 1'b0;
      debug_we  <= 1'b0;

      case (state)
        IDLE: begin
          if (req) begin
            if (addr_err) begin
              err_q     <= 1'b1;
              wbs_dat_o <= '0;
              state     <= ACK;
            end else if (region == REG_DEBUG && !wbs_we_i) begin
              // Debug reads present the index now and sample debug_rdata
              // after the configured number of wait cycles.
              debug_sel  <= wbs_adr_i[LOG_CORES+4:5];
              debug_addr <= wbs_adr_i[4:0];
              wait_cnt   <= 4'(DEBUG_LATENCY);
              state      <= DWAIT;
            end else begin
              wbs_ack_o <= 1'b1;
              state     <= ACK;
              case (region)
                REG_PROG: begin
                  if (wbs_we_i) begin
                    prog_sel   <= wbs_adr_i[PC_WIDTH+LOG_CORES-1:PC_WIDTH];
                    prog_waddr <= wbs_adr_i[PC_WIDTH-1:0];
                    prog_wdata <= wbs_dat_i[INSTR_WIDTH-1:0];
                    prog_we    <= 1'b1;
                  end else begin
                    wbs_dat_o <= '0;
                  end
                end
                REG_PADS: begin
                  if (wbs_we_i) begin
                    pads_waddr <= wbs_adr_i[LOG_PADS-1:0];
                    pads_wdata <= wbs_dat_i[IO_PINS-1:0];
                    pads_we    <= 1'b1;
                  end else begin
                    wbs_dat_o <= '0;
                  end
                end
                REG_DEBUG: begin
                  debug_sel   <= wbs_adr_i[LOG_CORES+4:5];
                  debug_addr  <= wbs_adr_i[4:0];
                  debug_wdata <= wbs_dat_i[DATA_WIDTH-1:0];
                  debug_we    <= 1'b1;
                end
                default: begin
                  // Entropy: reads return the pre-update pool; writes fold
                  // each selected byte in with XOR.
                  if (wbs_we_i) begin
                    for (int b = 0; b < WB_WIDTH / 8; b++) begin
                      if (wbs_sel_i[b]) begin
                        entropy_word[b*8 +: 8] <= entropy_word[b*8 +: 8] ^ wbs_dat_i[b*8 +: 8];
                      end
                    end
                  end else begin
                    wbs_dat_o <= entropy_word;
                  end
                end
              endcase
            end
          end
        end

        DWAIT: begin
          // Dropping cyc abandons the read silently; dat_o keeps its value.
          if (!wbs_cyc_i) begin
            wait_cnt <= 4'd0;
            state    <= IDLE;
          end else if (wait_cnt <= 4'd1) begin
            wait_cnt  <= 4'd0;
            wbs_dat_o <= WB_WIDTH'(debug_rdata);
            wbs_ack_o <= 1'b1;
            state     <= ACK;
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end

        ACK: begin
          // stb is deliberately not sampled here, so a held strobe is seen
          // as a new request only after one idle cycle.
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_regmux.sv
// -----------------------------------------------------------------------------
// tb_wb_regmux
//
// Self-checking bench for wb_regmux. Each scenario task drives bus requests,
// pushes the expected read data / latency / error onto a scoreboard queue and
// pops it when the DUT responds. Side outputs are compared inline against a
// small bench-side model of the entropy pool and the read data register.
// -----------------------------------------------------------------------------
module tb_wb_regmux;

  localparam int DLAT = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        stb, cyc, we;
  logic [3:0]  sel;
  logic [31:0] adr, dat_w;
  logic        ack, err;
  logic [31:0] dat_r;
  logic        prog_we;
  logic [2:0]  prog_sel;
  logic [7:0]  prog_waddr;
  logic [31:0] prog_wdata;
  logic        pads_we;
  logic [0:0]  pads_waddr;
  logic [15:0] pads_wdata;
  logic [2:0]  debug_sel;
  logic [4:0]  debug_addr;
  logic        debug_we;
  logic [15:0] debug_wdata;
  logic [15:0] debug_rdata;
  logic [31:0] entropy_word;

  int errors = 0;
  int checks = 0;

  // Expected response of one bus transfer.
  typedef struct {
    logic [31:0] dat;
    logic        err;
    int          lat;
  } exp_t;

  // Everything visible in the cycle the DUT answered.
  typedef struct {
    logic        ack;
    logic        err;
    logic [31:0] dat;
    int          lat;
    logic        prog_we;
    logic [2:0]  prog_sel;
    logic [7:0]  prog_waddr;
    logic [31:0] prog_wdata;
    logic        pads_we;
    logic [0:0]  pads_waddr;
    logic [15:0] pads_wdata;
    logic        debug_we;
    logic [2:0]  debug_sel;
    logic [4:0]  debug_addr;
    logic [15:0] debug_wdata;
  } obs_t;

  exp_t exp_q[$];

  logic [31:0] model_ent;
  logic [31:0] model_dato;

  int prog_we_cnt  = 0;
  int pads_we_cnt  = 0;
  int debug_we_cnt = 0;

  always #5 clk = ~clk;

  wb_regmux #(.DEBUG_LATENCY(DLAT)) dut (
    .wb_clk_i    (clk),
    .wb_rst_i    (rst),
    .wbs_stb_i   (stb),
    .wbs_cyc_i   (cyc),
    .wbs_we_i    (we),
    .wbs_sel_i   (sel),
    .wbs_adr_i   (adr),
    .wbs_dat_i   (dat_w),
    .wbs_ack_o   (ack),
    .wbs_err_o   (err),
    .wbs_dat_o   (dat_r),
    .prog_we     (prog_we),
    .prog_sel    (prog_sel),
    .prog_waddr  (prog_waddr),
    .prog_wdata  (prog_wdata),
    .pads_we     (pads_we),
    .pads_waddr  (pads_waddr),
    .pads_wdata  (pads_wdata),
    .debug_sel   (debug_sel),
    .debug_addr  (debug_addr),
    .debug_we    (debug_we),
    .debug_wdata (debug_wdata),
    .debug_rdata (debug_rdata),
    .entropy_word(entropy_word)
  );

  // Count cycles each write strobe is high, to catch stray or long pulses.
  always @(posedge clk) begin
    if (prog_we  === 1'b1) prog_we_cnt++;
    if (pads_we  === 1'b1) pads_we_cnt++;
    if (debug_we === 1'b1) debug_we_cnt++;
  end

  // Reference for the byte-masked XOR accumulate.
  function automatic logic [31:0] ent_xor(input logic [31:0] cur, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] r;
    r = cur;
    for (int b = 0; b < 4; b++) if (s[b]) r[b*8 +: 8] = cur[b*8 +: 8] ^ d[b*8 +: 8];
    return r;
  endfunction

  // Classic Wishbone transfer: hold stb/cyc until ack or err, bounded.
  // A timeout leaves lat at 0, which never matches an expectation.
  task automatic bus_xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] s, output obs_t o);
    @(negedge clk);
    stb = 1'b1; cyc = 1'b1; we = w; adr = a; dat_w = d; sel = s;
    o = '{default: '0};
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (ack === 1'b1 || err === 1'b1) begin
        o.ack = ack; o.err = err; o.dat = dat_r; o.lat = i;
        o.prog_we = prog_we; o.prog_sel = prog_sel; o.prog_waddr = prog_waddr; o.prog_wdata = prog_wdata;
        o.pads_we = pads_we; o.pads_waddr = pads_waddr; o.pads_wdata = pads_wdata;
        o.debug_we = debug_we; o.debug_sel = debug_sel; o.debug_addr = debug_addr; o.debug_wdata = debug_wdata;
        break;
      end
    end
    stb = 1'b0; cyc = 1'b0; we = 1'b0;
  endtask

  // Idle/reset state of every output.
  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    model_ent = 32'h1;
    model_dato = 32'h0;
    checks++; if ({ack, err} !== 2'b00) begin errors++; $display("[TB] FAIL reset_ack_err: got %b expected 00", {ack, err}); end
    checks++; if (dat_r !== 32'h0) begin errors++; $display("[TB] FAIL reset_dat: got %h expected 0", dat_r); end
    checks++; if ({prog_we, pads_we, debug_we} !== 3'b000) begin errors++; $display("[TB] FAIL reset_we: got %b expected 000", {prog_we, pads_we, debug_we}); end
    checks++; if ({prog_sel, prog_waddr, prog_wdata, pads_waddr, pads_wdata, debug_sel, debug_addr, debug_wdata} !== '0) begin
      errors++; $display("[TB] FAIL reset_fields: got nonzero expected 0"); end
    checks++; if (entropy_word !== 32'h1) begin errors++; $display("[TB] FAIL reset_entropy: got %h expected 00000001", entropy_word); end
  endtask

  task automatic test_prog_write();
    obs_t o; exp_t e;
    exp_q.push_back('{dat: model_dato, err: 1'b0, lat: 1});
    bus_xfer(1'b1, 32'h000005DB, 32'hFFFFFFFF, 4'hF, o);
    e = exp_q.pop_front();
    checks++; if ({o.lat, o.ack, o.err, o.dat} !== {e.lat, ~e.err, e.err, e.dat}) begin errors++;
      $display("[TB] FAIL prog_resp: got lat=%0d ack=%b err=%b dat=%h expected lat=%0d err=%b dat=%h", o.lat, o.ack, o.err, o.dat, e.lat, e.err, e.dat); end
    checks++; if ({o.prog_we, o.prog_sel, o.prog_waddr, o.prog_wdata} !== {1'b1, 3'b101, 8'hDB, 32'hFFFFFFFF}) begin errors++;
      $display("[TB] FAIL prog_port: got we=%b sel=%h waddr=%h wdata=%h expected 1 5 db ffffffff", o.prog_we, o.prog_sel, o.prog_waddr, o.prog_wdata); end
    @(negedge clk);
    checks++; if ({prog_we, ack} !== 2'b00) begin errors++; $display("[TB] FAIL prog_pulse_end: got we,ack=%b expected 00", {prog_we, ack}); end
    checks++; if (prog_we_cnt !== 1) begin errors++; $display("[TB] FAIL prog_we_count: got %0d expected 1", prog_we_cnt); end
  endtask

  task automatic test_debug_read();
    obs_t o; exp_t e; int dbg_before;
    dbg_before = debug_we_cnt;
    debug_rdata = 16'hF0AA;
    model_dato = 32'h0000F0AA;
    exp_q.push_back('{dat: model_dato, err: 1'b0, lat: DLAT + 1});
    bus_xfer(1'b0, 32'h8000004A, 32'h0, 4'hF, o);
    e = exp_q.pop_front();
    checks++; if ({o.lat, o.ack, o.err, o.dat} !== {e.lat, ~e.err, e.err, e.dat}) begin errors++;
      $display("[TB] FAIL dbg_read_resp: got lat=%0d ack=%b err=%b dat=%h expected lat=%0d err=%b dat=%h", o.lat, o.ack, o.err, o.dat, e.lat, e.err, e.dat); end
    checks++; if ({o.debug_sel, o.debug_addr} !== {3'b010, 5'h0A}) begin errors++;
      $display("[TB] FAIL dbg_read_index: got sel=%h addr=%h expected 2 0a", o.debug_sel, o.debug_addr); end
    @(negedge clk);
    checks++; if (debug_we_cnt !== dbg_before) begin errors++; $display("[TB] FAIL dbg_read_no_we: got %0d pulses expected 0", debug_we_cnt - dbg_before); end
  endtask

  task automatic test_debug_write();
    obs_t o; exp_t e;
    exp_q.push_back('{dat: model_dato, err: 1'b0, lat: 1});
    bus_xfer(1'b1, 32'h800000E3, 32'h7777BEEF, 4'hF, o);
    e = exp_q.pop_front();
    checks++; if ({o.lat, o.ack, o.err, o.dat} !== {e.lat, ~e.err, e.err, e.dat}) begin errors++;
      $display("[TB] FAIL dbg_write_resp: got lat=%0d ack=%b err=%b dat=%h expected lat=%0d dat=%h", o.lat, o.ack, o.err, o.dat, e.lat, e.dat); end
    checks++; if ({o.debug_we, o.debug_sel, o.debug_addr, o.debug_wdata} !== {1'b1, 3'b111, 5'h03, 16'hBEEF}) begin errors++;
      $display("[TB] FAIL dbg_write_port: got we=%b sel=%h addr=%h wdata=%h expected 1 7 03 beef", o.debug_we, o.debug_sel, o.debug_addr, o.debug_wdata); end
    @(negedge clk);
    checks++; if (debug_we !== 1'b0) begin errors++; $display("[TB] FAIL dbg_we_end: got %b expected 0", debug_we); end
  endtask

  // Byte-masked XOR writes including an empty mask, then a read back.
  task automatic test_entropy();
    obs_t o; exp_t e;
    logic [31:0] wd [3];
    logic [3:0]  ws [3];
    wd[0] = 32'hFFFFFFFF; ws[0] = 4'b0011;
    wd[1] = 32'hDEADBEEF; ws[1] = 4'b0000;
    wd[2] = 32'h12345678; ws[2] = 4'b1100;
    for (int i = 0; i < 3; i++) begin
      model_ent = ent_xor(model_ent, wd[i], ws[i]);
      exp_q.push_back('{dat: model_dato, err: 1'b0, lat: 1});
      bus_xfer(1'b1, 32'hC0000000, wd[i], ws[i], o);
      e = exp_q.pop_front();
      checks++; if ({o.lat, o.ack, o.err} !== {e.lat, 1'b1, 1'b0}) begin errors++;
        $display("[TB] FAIL ent_write_resp[%0d]: got lat=%0d ack=%b err=%b expected lat=1 ack=1", i, o.lat, o.ack, o.err); end
      checks++; if (entropy_word !== model_ent) begin errors++;
        $display("[TB] FAIL ent_word[%0d]: got %h expected %h", i, entropy_word, model_ent); end
    end
    model_dato = model_ent;
    exp_q.push_back('{dat: model_dato, err: 1'b0, lat: 1});
    bus_xfer(1'b0, 32'hC0000000, 32'h0, 4'hF, o);
    e = exp_q.pop_front();
    checks++; if ({o.lat, o.ack, o.err, o.dat} !== {e.lat, ~e.err, e.err, e.dat}) begin errors++;
      $display("[TB] FAIL ent_read: got lat=%0d ack=%b err=%b dat=%h expected lat=%0d dat=%h", o.lat, o.ack, o.err, o.dat, e.lat, e.dat); end
    @(negedge clk);
    checks++; if (ack !== 1'b0) begin errors++; $display("[TB] FAIL ent_read_ack_end: got %b expected 0", ack); end
  endtask

  task automatic test_pads();
    obs_t o; exp_t e; int pads_before;
    exp_q.push_back('{dat: model_dato, err: 1'b0, lat: 1});
    bus_xfer(1'b1, 32'h40000001, 32'h1234ABCD, 4'hF, o);
    e = exp_q.pop_front();
    checks++; if ({o.lat, o.ack, o.pads_we, o.pads_waddr, o.pads_wdata} !== {e.lat, 1'b1, 1'b1, 1'b1, 16'hABCD}) begin errors++;
      $display("[TB] FAIL pads_write: got lat=%0d ack=%b we=%b waddr=%b wdata=%h expected 1 1 1 1 abcd", o.lat, o.ack, o.pads_we, o.pads_waddr, o.pads_wdata); end
    @(negedge clk);
    checks++; if (pads_we !== 1'b0) begin errors++; $display("[TB] FAIL pads_we_end: got %b expected 0", pads_we); end
    pads_before = pads_we_cnt;
    model_dato = 32'h0;
    exp_q.push_back('{dat: model_dato, err: 1'b0, lat: 1});
    bus_xfer(1'b0, 32'h40000001, 32'h0, 4'hF, o);
    e = exp_q.pop_front();
    checks++; if ({o.lat, o.ack, o.err, o.dat} !== {e.lat, ~e.err, e.err, e.dat}) begin errors++;
      $display("[TB] FAIL pads_read: got lat=%0d ack=%b dat=%h expected lat=1 ack=1 dat=%h", o.lat, o.ack, o.dat, e.dat); end
    @(negedge clk);
    checks++; if (pads_we_cnt !== pads_before) begin errors++; $display("[TB] FAIL pads_read_no_we: got %0d pulses expected 0", pads_we_cnt - pads_before); end
  endtask

  // Strobe held high across two entropy reads: ack, idle, ack, idle.
  task automatic test_back_to_back();
    logic [3:0] seen;
    exp_t e;
    seen = 4'b0;
    model_dato = model_ent;
    exp_q.push_back('{dat: model_dato, err: 1'b0, lat: 1});
    exp_q.push_back('{dat: model_dato, err: 1'b0, lat: 3});
    @(negedge clk);
    stb = 1'b1; cyc = 1'b1; we = 1'b0; adr = 32'hC0000000; sel = 4'hF;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      seen[i-1] = ack;
      if (ack === 1'b1 && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++; if ({i, dat_r} !== {e.lat, e.dat}) begin errors++;
          $display("[TB] FAIL b2b_resp: got cycle=%0d dat=%h expected cycle=%0d dat=%h", i, dat_r, e.lat, e.dat); end
      end
      if (i == 3) begin stb = 1'b0; cyc = 1'b0; end
    end
    stb = 1'b0; cyc = 1'b0;
    checks++; if (seen !== 4'b0101) begin errors++; $display("[TB] FAIL b2b_pattern: got %b expected 0101", seen); end
    checks++; if (exp_q.size() !== 0) begin errors++; $display("[TB] FAIL b2b_missing_ack: got %0d pending expected 0", exp_q.size()); exp_q.delete(); end
  endtask

  // Drop cyc mid-wait: no ack, dat_o kept, slave idle afterwards.
  task automatic test_abort();
    int acks; obs_t o; exp_t e;
    acks = 0;
    debug_rdata = 16'h5555;
    @(negedge clk);
    stb = 1'b1; cyc = 1'b1; we = 1'b0; adr = 32'h8000004A;
    @(negedge clk);
    if (ack === 1'b1 || err === 1'b1) acks++;
    @(negedge clk);
    if (ack === 1'b1 || err === 1'b1) acks++;
    stb = 1'b0; cyc = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (ack === 1'b1 || err === 1'b1) acks++;
    end
    checks++; if (acks !== 0) begin errors++; $display("[TB] FAIL abort_ack: got %0d acks expected 0", acks); end
    checks++; if (dat_r !== model_dato) begin errors++; $display("[TB] FAIL abort_dat: got %h expected %h", dat_r, model_dato); end
    model_dato = model_ent;
    exp_q.push_back('{dat: model_dato, err: 1'b0, lat: 1});
    bus_xfer(1'b0, 32'hC0000000, 32'h0, 4'hF, o);
    e = exp_q.pop_front();
    checks++; if ({o.lat, o.ack, o.dat} !== {e.lat, 1'b1, e.dat}) begin errors++;
      $display("[TB] FAIL abort_then_idle: got lat=%0d ack=%b dat=%h expected lat=1 ack=1 dat=%h", o.lat, o.ack, o.dat, e.dat); end
  endtask

  // Reset during a debug wait drops the ack and restores every register.
  task automatic test_reset_mid();
    int acks;
    acks = 0;
    checks++; if (entropy_word === 32'h1) begin errors++; $display("[TB] FAIL rst_mid_precond: got %h expected non-seed", entropy_word); end
    @(negedge clk);
    stb = 1'b1; cyc = 1'b1; we = 1'b0; adr = 32'h8000004A;
    @(negedge clk);
    rst = 1'b1; stb = 1'b0; cyc = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (ack === 1'b1 || err === 1'b1) acks++;
    end
    model_ent = 32'h1;
    model_dato = 32'h0;
    checks++; if (acks !== 0) begin errors++; $display("[TB] FAIL rst_mid_ack: got %0d acks expected 0", acks); end
    checks++; if (entropy_word !== model_ent) begin errors++; $display("[TB] FAIL rst_mid_entropy: got %h expected %h", entropy_word, model_ent); end
    checks++; if ({dat_r, debug_sel, debug_addr, prog_sel, prog_wdata} !== '0) begin errors++;
      $display("[TB] FAIL rst_mid_regs: got dat=%h dsel=%h daddr=%h psel=%h pwdata=%h expected all 0", dat_r, debug_sel, debug_addr, prog_sel, prog_wdata); end
  endtask

  // Stray address bits: error with the check enabled, aliasing without it.
  task automatic test_addr_check();
    obs_t o; exp_t e; int prog_before;
    prog_before = prog_we_cnt;
`ifdef WB_REGMUX_ADDR_CHECK_EN
    model_dato = 32'h0;
    exp_q.push_back('{dat: model_dato, err: 1'b1, lat: 1});
`else
    exp_q.push_back('{dat: model_dato, err: 1'b0, lat: 1});
`endif
    bus_xfer(1'b1, 32'h00010000, 32'hA5A5A5A5, 4'hF, o);
    e = exp_q.pop_front();
    checks++; if ({o.lat, o.ack, o.err, o.dat} !== {e.lat, ~e.err, e.err, e.dat}) begin errors++;
      $display("[TB] FAIL addr_chk_resp: got lat=%0d ack=%b err=%b dat=%h expected lat=%0d err=%b dat=%h", o.lat, o.ack, o.err, o.dat, e.lat, e.err, e.dat); end
    @(negedge clk);
`ifdef WB_REGMUX_ADDR_CHECK_EN
    checks++; if (prog_we_cnt !== prog_before) begin errors++; $display("[TB] FAIL addr_chk_no_write: got %0d pulses expected 0", prog_we_cnt - prog_before); end
`else
    checks++; if ({o.prog_we, o.prog_sel, o.prog_waddr, o.prog_wdata} !== {1'b1, 3'b000, 8'h00, 32'hA5A5A5A5}) begin errors++;
      $display("[TB] FAIL addr_alias_write: got we=%b sel=%h waddr=%h wdata=%h expected 1 0 00 a5a5a5a5", o.prog_we, o.prog_sel, o.prog_waddr, o.prog_wdata); end
    checks++; if (prog_we_cnt !== prog_before + 1) begin errors++; $display("[TB] FAIL addr_alias_count: got %0d pulses expected 1", prog_we_cnt - prog_before); end
`endif
  endtask

  initial begin
    rst = 1'b1; stb = 1'b0; cyc = 1'b0; we = 1'b0; sel = 4'h0;
    adr = 32'h0; dat_w = 32'h0; debug_rdata = 16'h0;
    model_ent = 32'h1; model_dato = 32'h0;
    $display("[TB] starting wb_regmux bench, DEBUG_LATENCY=%0d", DLAT);
    test_reset();
    test_prog_write();
    test_debug_read();
    test_debug_write();
    test_entropy();
    test_pads();
    test_back_to_back();
    test_abort();
    test_reset_mid();
    test_addr_check();
    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
